// File: rtl/pipelined_alu_unit_if.sv
// Issue/writeback bundle for pipelined_alu_unit.
// master: issue side (drives request, branch update and flush; receives resp/bypass/busy).
// slave:  the ALU unit itself.
// Bypass vectors are flat; slice k belongs to stage k (slot 0 is the issuing uop).
interface pipelined_alu_unit_if #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned STAGES    = 1,
   parameter int unsigned BR_MASK_W = 20,
   parameter int unsigned ROB_IDX_W = 7,
   parameter int unsigned PREG_W    = 7
);
   logic                      io_req_valid;
   logic [3:0]                io_req_fn;
   logic                      io_req_dw;
   logic [XLEN-1:0]           io_req_in1;
   logic [XLEN-1:0]           io_req_in2;
   logic [BR_MASK_W-1:0]      io_req_br_mask;
   logic [ROB_IDX_W-1:0]      io_req_rob_idx;
   logic [PREG_W-1:0]         io_req_pdst;
   logic [1:0]                io_req_dst_rtype;
   logic                      io_req_kill;
   logic [BR_MASK_W-1:0]      io_brupdate_resolve_mask;
   logic [BR_MASK_W-1:0]      io_brupdate_mispredict_mask;
   logic                      io_flush;

   logic                      io_resp_valid;
   logic [ROB_IDX_W-1:0]      io_resp_rob_idx;
   logic [PREG_W-1:0]         io_resp_pdst;
   logic [1:0]                io_resp_dst_rtype;
   logic [XLEN-1:0]           io_resp_data;
   logic [STAGES-1:0]         io_bypass_valid;
   logic [STAGES*PREG_W-1:0]  io_bypass_pdst;
   logic [STAGES*2-1:0]       io_bypass_dst_rtype;
   logic [STAGES*XLEN-1:0]    io_bypass_data;
   logic                      io_busy;

   modport master (
      output io_req_valid, io_req_fn, io_req_dw, io_req_in1, io_req_in2, io_req_br_mask,
             io_req_rob_idx, io_req_pdst, io_req_dst_rtype, io_req_kill,
             io_brupdate_resolve_mask, io_brupdate_mispredict_mask, io_flush,
      input  io_resp_valid, io_resp_rob_idx, io_resp_pdst, io_resp_dst_rtype, io_resp_data,
             io_bypass_valid, io_bypass_pdst, io_bypass_dst_rtype, io_bypass_data, io_busy
   );

   modport slave (
      input  io_req_valid, io_req_fn, io_req_dw, io_req_in1, io_req_in2, io_req_br_mask,
             io_req_rob_idx, io_req_pdst, io_req_dst_rtype, io_req_kill,
             io_brupdate_resolve_mask, io_brupdate_mispredict_mask, io_flush,
      output io_resp_valid, io_resp_rob_idx, io_resp_pdst, io_resp_dst_rtype, io_resp_data,
             io_bypass_valid, io_bypass_pdst, io_bypass_dst_rtype, io_bypass_data, io_busy
   );
endinterface

// File: rtl/pipelined_alu_unit.sv
// Integer ALU execution unit with a fixed STAGES-cycle result latency.
// Ports:
//   clock  - clock
//   reset  - asynchronous active-low reset
//   io     - pipelined_alu_unit_if.slave: request, branch update, flush, writeback
//            response, per-stage bypass and busy.
// The result is computed combinationally at issue and carried with the uop tags down a
// no-stall pipeline. Every stage drops uops hit by a flush or a mispredicted branch and
// clears resolved branch bits as the uop moves forward.
module pipelined_alu_unit #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned STAGES    = 1,
   parameter int unsigned BR_MASK_W = 20,
   parameter int unsigned ROB_IDX_W = 7,
   parameter int unsigned PREG_W    = 7
) (
   input logic                clock,
   input logic                reset,
   pipelined_alu_unit_if.slave io
);

   localparam int unsigned ShW = (XLEN == 64) ? 6 : 5;

   typedef enum logic [3:0] {
      FnAdd  = 4'd0,
      FnSll  = 4'd1,
      FnSlt  = 4'd2,
      FnSltu = 4'd3,
      FnXor  = 4'd4,
      FnSrl  = 4'd5,
      FnOr   = 4'd6,
      FnAnd  = 4'd7,
      FnSub  = 4'd8,
      FnSra  = 4'd13,
      FnCopy = 4'd15
   } alu_fn_e;

   function automatic logic killed(input logic [BR_MASK_W-1:0] mask,
                                   input logic [BR_MASK_W-1:0] mispredict,
                                   input logic                 flush);
      return flush | (|(mispredict & mask));
   endfunction

   // ------------------------------------------------------------------
   // Combinational ALU
   // ------------------------------------------------------------------
   logic [XLEN-1:0] res_full;
   logic [XLEN-1:0] res_ext;
   logic [XLEN-1:0] result;
   logic [31:0]     a32;
   logic [31:0]     b32;
   logic [31:0]     res32;
   logic [ShW-1:0]  sh_full;
   logic [4:0]      sh32;
   logic            word_op;
   logic            is_cmp;

   always_comb begin
      a32      = io.io_req_in1[31:0];
      b32      = io.io_req_in2[31:0];
      sh_full  = io.io_req_in2[ShW-1:0];
      sh32     = io.io_req_in2[4:0];
      word_op  = (XLEN == 64) && !io.io_req_dw;
      is_cmp   = 1'b0;
      res_full = '0;
      res32    = '0;
      case (io.io_req_fn)
         FnAdd: begin
            res_full = io.io_req_in1 + io.io_req_in2;
            res32    = a32 + b32;
         end
         FnSub: begin
            res_full = io.io_req_in1 - io.io_req_in2;
            res32    = a32 - b32;
         end
         FnSll: begin
            res_full = io.io_req_in1 << sh_full;
            res32    = a32 << sh32;
         end
         FnSrl: begin
            res_full = io.io_req_in1 >> sh_full;
            res32    = a32 >> sh32;
         end
         FnSra: begin
            res_full = $unsigned($signed(io.io_req_in1) >>> sh_full);
            res32    = $unsigned($signed(a32) >>> sh32);
         end
         // Compares always use the full datapath width, even for word ops.
         FnSlt: begin
            is_cmp      = 1'b1;
            res_full[0] = $signed(io.io_req_in1) < $signed(io.io_req_in2);
         end
         FnSltu: begin
            is_cmp      = 1'b1;
            res_full[0] = io.io_req_in1 < io.io_req_in2;
         end
         FnXor: begin
            res_full = io.io_req_in1 ^ io.io_req_in2;
            res32    = a32 ^ b32;
         end
         FnOr: begin
            res_full = io.io_req_in1 | io.io_req_in2;
            res32    = a32 | b32;
         end
         FnAnd: begin
            res_full = io.io_req_in1 & io.io_req_in2;
            res32    = a32 & b32;
         end
         FnCopy: begin
            res_full = io.io_req_in2;
            res32    = b32;
         end
         default: begin
            res_full = '0;
            res32    = '0;
         end
      endcase
      res_ext       = {XLEN{res32[31]}};
      res_ext[31:0] = res32;
      result        = (word_op && !is_cmp) ? res_ext : res_full;
   end

   // ------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------
   logic [STAGES-1:0]    valid_q, valid_d;
   logic [BR_MASK_W-1:0] mask_q  [STAGES];
   logic [BR_MASK_W-1:0] mask_d  [STAGES];
   logic [ROB_IDX_W-1:0] rob_q   [STAGES];
   logic [ROB_IDX_W-1:0] rob_d   [STAGES];
   logic [PREG_W-1:0]    pdst_q  [STAGES];
   logic [PREG_W-1:0]    pdst_d  [STAGES];
   logic [1:0]           rtype_q [STAGES];
   logic [1:0]           rtype_d [STAGES];
   logic [XLEN-1:0]      data_q  [STAGES];
   logic [XLEN-1:0]      data_d  [STAGES];

   always_comb begin
      valid_d[0] = io.io_req_valid & ~io.io_req_kill &
                   ~killed(io.io_req_br_mask, io.io_brupdate_mispredict_mask, io.io_flush);
      mask_d[0]  = io.io_req_br_mask & ~io.io_brupdate_resolve_mask;
      rob_d[0]   = io.io_req_rob_idx;
      pdst_d[0]  = io.io_req_pdst;
      rtype_d[0] = io.io_req_dst_rtype;
      data_d[0]  = result;
      for (int k = 1; k < STAGES; k++) begin
         // Kill check uses the pre-resolve mask so a same-cycle resolve cannot save a uop.
         valid_d[k] = valid_q[k-1] &
                      ~killed(mask_q[k-1], io.io_brupdate_mispredict_mask, io.io_flush);
         mask_d[k]  = mask_q[k-1] & ~io.io_brupdate_resolve_mask;
         rob_d[k]   = rob_q[k-1];
         pdst_d[k]  = pdst_q[k-1];
         rtype_d[k] = rtype_q[k-1];
         data_d[k]  = data_q[k-1];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            mask_q[k]  <= '0;
            rob_q[k]   <= '0;
            pdst_q[k]  <= '0;
            rtype_q[k] <= '0;
            data_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < STAGES; k++) begin
            mask_q[k]  <= mask_d[k];
            rob_q[k]   <= rob_d[k];
            pdst_q[k]  <= pdst_d[k];
            rtype_q[k] <= rtype_d[k];
            data_q[k]  <= data_d[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Writeback and bypass
   // ------------------------------------------------------------------
   logic [STAGES-1:0]        byp_valid;
   logic [STAGES*PREG_W-1:0] byp_pdst;
   logic [STAGES*2-1:0]      byp_rtype;
   logic [STAGES*XLEN-1:0]   byp_data;
   logic                     resp_valid;

   always_comb begin
      byp_valid = '0;
      byp_pdst  = '0;
      byp_rtype = '0;
      byp_data  = '0;
      resp_valid = valid_q[STAGES-1] &
                   ~killed(mask_q[STAGES-1], io.io_brupdate_mispredict_mask, io.io_flush);
      // Slot 0 is a combinational path from the request; hold it quiet during reset.
      if (reset) begin
         byp_valid[0]      = io.io_req_valid & ~io.io_req_kill & ~io.io_flush;
         byp_pdst[PREG_W-1:0] = io.io_req_pdst;
         byp_rtype[1:0]    = io.io_req_dst_rtype;
         byp_data[XLEN-1:0] = result;
      end
      for (int k = 1; k < STAGES; k++) begin
         byp_valid[k] = valid_q[k-1] &
                        ~killed(mask_q[k-1], io.io_brupdate_mispredict_mask, io.io_flush);
         byp_pdst[k*PREG_W +: PREG_W] = pdst_q[k-1];
         byp_rtype[k*2 +: 2]          = rtype_q[k-1];
         byp_data[k*XLEN +: XLEN]     = data_q[k-1];
      end
   end

   assign io.io_resp_valid       = resp_valid;
   assign io.io_resp_rob_idx     = rob_q[STAGES-1];
   assign io.io_resp_pdst        = pdst_q[STAGES-1];
   assign io.io_resp_dst_rtype   = rtype_q[STAGES-1];
   assign io.io_resp_data        = data_q[STAGES-1];
   assign io.io_bypass_valid     = byp_valid;
   assign io.io_bypass_pdst      = byp_pdst;
   assign io.io_bypass_dst_rtype = byp_rtype;
   assign io.io_bypass_data      = byp_data;
   assign io.io_busy             = |valid_q;

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// Bench for pipelined_alu_unit: three instances (STAGES = 1, 3, 4) share one stimulus.
module tb_pipelined_alu_unit;

   localparam int unsigned XLEN = 64;
   localparam int unsigned BMW  = 20;
   localparam int unsigned RW   = 7;
   localparam int unsigned PW   = 7;
   localparam int          NCFG = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic            req_valid, req_dw, req_kill, flush;
   logic [3:0]      req_fn;
   logic [XLEN-1:0] req_in1, req_in2;
   logic [BMW-1:0]  req_br_mask, resolve, mispredict;
   logic [RW-1:0]   req_rob_idx;
   logic [PW-1:0]   req_pdst;
   logic [1:0]      req_dst_rtype;

   logic            obs_resp_valid [NCFG];
   logic [RW-1:0]   obs_resp_rob   [NCFG];
   logic [PW-1:0]   obs_resp_pdst  [NCFG];
   logic [1:0]      obs_resp_rtype [NCFG];
   logic [XLEN-1:0] obs_resp_data  [NCFG];
   logic            obs_busy       [NCFG];
   logic            obs_byp_valid  [NCFG][4];
   logic [PW-1:0]   obs_byp_pdst   [NCFG][4];
   logic [1:0]      obs_byp_rtype  [NCFG][4];
   logic [XLEN-1:0] obs_byp_data   [NCFG][4];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      pipelined_alu_unit_if #(.XLEN(XLEN), .STAGES(S), .BR_MASK_W(BMW), .ROB_IDX_W(RW),
                              .PREG_W(PW)) bus ();
      assign bus.io_req_valid                = req_valid;
      assign bus.io_req_fn                   = req_fn;
      assign bus.io_req_dw                   = req_dw;
      assign bus.io_req_in1                  = req_in1;
      assign bus.io_req_in2                  = req_in2;
      assign bus.io_req_br_mask              = req_br_mask;
      assign bus.io_req_rob_idx              = req_rob_idx;
      assign bus.io_req_pdst                 = req_pdst;
      assign bus.io_req_dst_rtype            = req_dst_rtype;
      assign bus.io_req_kill                 = req_kill;
      assign bus.io_brupdate_resolve_mask    = resolve;
      assign bus.io_brupdate_mispredict_mask = mispredict;
      assign bus.io_flush                    = flush;

      pipelined_alu_unit #(.XLEN(XLEN), .STAGES(S), .BR_MASK_W(BMW), .ROB_IDX_W(RW),
                           .PREG_W(PW)) u_dut (
         .clock (clock),
         .reset (reset),
         .io    (bus)
      );

      assign obs_resp_valid[g] = bus.io_resp_valid;
      assign obs_resp_rob[g]   = bus.io_resp_rob_idx;
      assign obs_resp_pdst[g]  = bus.io_resp_pdst;
      assign obs_resp_rtype[g] = bus.io_resp_dst_rtype;
      assign obs_resp_data[g]  = bus.io_resp_data;
      assign obs_busy[g]       = bus.io_busy;
      for (genvar k = 0; k < 4; k++) begin : g_slot
         if (k < S) begin : g_on
            assign obs_byp_valid[g][k] = bus.io_bypass_valid[k];
            assign obs_byp_pdst[g][k]  = bus.io_bypass_pdst[k*PW +: PW];
            assign obs_byp_rtype[g][k] = bus.io_bypass_dst_rtype[k*2 +: 2];
            assign obs_byp_data[g][k]  = bus.io_bypass_data[k*XLEN +: XLEN];
         end else begin : g_off
            assign obs_byp_valid[g][k] = 1'b0;
            assign obs_byp_pdst[g][k]  = '0;
            assign obs_byp_rtype[g][k] = '0;
            assign obs_byp_data[g][k]  = '0;
         end
      end
   end

   typedef struct packed {
      logic            alive;
      logic [BMW-1:0]  mask;
      logic [XLEN-1:0] data;
      logic [RW-1:0]   rob;
      logic [PW-1:0]   pdst;
      logic [1:0]      rtype;
   } uop_t;

   function automatic int stg(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
   endfunction

   // Reference ALU written straight from the opcode table.
   function automatic logic [63:0] alu_ref(input logic [3:0] fn, input logic dw,
                                           input logic [63:0] a, input logic [63:0] b);
      longint sa, sb, lw;
      int     w, sh;
      logic [63:0] r;
      sa = a;
      sb = b;
      if (fn == 4'd2) return {63'b0, (sa < sb)};
      if (fn == 4'd3) return {63'b0, (a < b)};
      sh = dw ? int'(b[5:0]) : int'(b[4:0]);
      case (fn)
         4'd0:  r = a + b;
         4'd8:  r = a - b;
         4'd1:  r = a << sh;
         4'd4:  r = a ^ b;
         4'd6:  r = a | b;
         4'd7:  r = a & b;
         4'd15: r = b;
         4'd5:  r = dw ? (a >> sh) : ({32'b0, a[31:0]} >> sh);
         4'd13: begin
            if (dw) begin
               lw = sa >>> sh;
            end else begin
               w  = a[31:0];
               lw = w >>> sh;
            end
            r = lw;
         end
         default: r = 64'd0;
      endcase
      if (!dw) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   task automatic clear_inputs();
      req_valid = 0; req_fn = 0; req_dw = 1; req_in1 = 0; req_in2 = 0; req_br_mask = 0;
      req_rob_idx = 0; req_pdst = 0; req_dst_rtype = 0; req_kill = 0;
      resolve = 0; mispredict = 0; flush = 0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) next_cycle();
   endtask

   task automatic issue(input logic [3:0] fn, input logic dw, input logic [63:0] a,
                        input logic [63:0] b, input logic [BMW-1:0] mask,
                        input logic [RW-1:0] rob, input logic [PW-1:0] pdst);
      req_valid = 1; req_fn = fn; req_dw = dw; req_in1 = a; req_in2 = b;
      req_br_mask = mask; req_rob_idx = rob; req_pdst = pdst; req_dst_rtype = 2'd1;
   endtask

   task automatic test_reset();
      clear_inputs();
      #2;
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (obs_resp_valid[g] !== 1'b0 || obs_busy[g] !== 1'b0 || obs_resp_data[g] !== '0) begin
            errors++;
            $display("FAIL reset_hold cfg%0d: got valid=%b busy=%b data=%h, expected 0/0/0",
                     g, obs_resp_valid[g], obs_busy[g], obs_resp_data[g]);
         end
      end
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) next_cycle();
      #4;
      for (int g = 0; g < NCFG; g++) begin
         for (int k = 0; k < stg(g); k++) begin
            checks++;
            if (obs_byp_valid[g][k] !== 1'b0 || obs_byp_data[g][k] !== '0) begin
               errors++;
               $display("FAIL post_reset_bypass cfg%0d slot%0d: got %b/%h, expected 0/0",
                        g, k, obs_byp_valid[g][k], obs_byp_data[g][k]);
            end
         end
         checks++;
         if (obs_resp_valid[g] !== 1'b0 || obs_busy[g] !== 1'b0 || obs_resp_pdst[g] !== '0) begin
            errors++;
            $display("FAIL post_reset_resp cfg%0d: got valid=%b busy=%b pdst=%0d, expected 0",
                     g, obs_resp_valid[g], obs_busy[g], obs_resp_pdst[g]);
         end
      end
      next_cycle();
   endtask

   task automatic test_alu();
      issue(4'd0, 1'b1, 64'd5, 64'd7, '0, 7'd9, 7'd3);
      #4;
      checks++;
      if (obs_byp_valid[0][0] !== 1'b1 || obs_byp_data[0][0] !== 64'd12) begin
         errors++;
         $display("FAIL add_slot0: got %b/%0d, expected 1/12", obs_byp_valid[0][0],
                  obs_byp_data[0][0]);
      end
      next_cycle();
      issue(4'd0, 1'b0, 64'h7FFF_FFFF, 64'd1, '0, 7'd10, 7'd4);
      #4;
      checks++;
      if (obs_resp_valid[0] !== 1'b1 || obs_resp_data[0] !== 64'd12 ||
          obs_resp_rob[0] !== 7'd9 || obs_resp_pdst[0] !== 7'd3 || obs_resp_rtype[0] !== 2'd1) begin
         errors++;
         $display("FAIL add_resp: got v=%b d=%0d rob=%0d pdst=%0d rt=%0d, expected 1/12/9/3/1",
                  obs_resp_valid[0], obs_resp_data[0], obs_resp_rob[0], obs_resp_pdst[0],
                  obs_resp_rtype[0]);
      end
      checks++;
      if (obs_byp_data[0][0] !== 64'hFFFF_FFFF_8000_0000) begin
         errors++;
         $display("FAIL addw_slot0: got %h, expected ffffffff80000000", obs_byp_data[0][0]);
      end
      checks++;
      if (obs_byp_valid[1][1] !== 1'b1 || obs_byp_data[1][1] !== 64'd12) begin
         errors++;
         $display("FAIL add_slot1_s3: got %b/%0d, expected 1/12", obs_byp_valid[1][1],
                  obs_byp_data[1][1]);
      end
      next_cycle();
      issue(4'd13, 1'b1, 64'h8000_0000_0000_0000, 64'd63, '0, 7'd11, 7'd5);
      #4;
      checks++;
      if (obs_resp_valid[0] !== 1'b1 || obs_resp_data[0] !== 64'hFFFF_FFFF_8000_0000) begin
         errors++;
         $display("FAIL addw_resp: got %b/%h, expected 1/ffffffff80000000", obs_resp_valid[0],
                  obs_resp_data[0]);
      end
      checks++;
      if (obs_byp_data[0][0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL sra_slot0: got %h, expected all ones", obs_byp_data[0][0]);
      end
      next_cycle();
      clear_inputs();
      #4;
      checks++;
      if (obs_resp_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF || obs_resp_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL sra_resp: got %b/%h, expected 1/all ones", obs_resp_valid[0],
                  obs_resp_data[0]);
      end
      checks++;
      if (obs_resp_valid[1] !== 1'b1 || obs_resp_data[1] !== 64'd12) begin
         errors++;
         $display("FAIL add_resp_s3: got %b/%0d, expected 1/12", obs_resp_valid[1],
                  obs_resp_data[1]);
      end
      next_cycle();
   endtask

   task automatic test_mispredict();
      issue(4'd0, 1'b1, 64'd1, 64'd2, 20'h4, 7'd1, 7'd1);
      next_cycle();
      clear_inputs();
      mispredict = 20'h4;
      #4;
      checks++;
      if (obs_byp_valid[1][1] !== 1'b0 || obs_busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL mispredict_c1: got slot1=%b busy=%b, expected 0/1", obs_byp_valid[1][1],
                  obs_busy[1]);
      end
      checks++;
      if (obs_resp_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL mispredict_resp_s1: got %b, expected 0", obs_resp_valid[0]);
      end
      next_cycle();
      mispredict = '0;
      #4;
      checks++;
      if (obs_busy[1] !== 1'b0 || obs_byp_valid[1][1] !== 1'b0 || obs_byp_valid[1][2] !== 1'b0) begin
         errors++;
         $display("FAIL mispredict_c2: got busy=%b s1=%b s2=%b, expected 0/0/0", obs_busy[1],
                  obs_byp_valid[1][1], obs_byp_valid[1][2]);
      end
      next_cycle();
      #4;
      checks++;
      if (obs_resp_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL mispredict_resp_s3: got %b, expected 0", obs_resp_valid[1]);
      end
      next_cycle();
   endtask

   task automatic test_resolve();
      issue(4'd0, 1'b1, 64'd3, 64'd4, 20'h6, 7'd2, 7'd2);
      resolve = 20'h2;
      next_cycle();
      clear_inputs();
      mispredict = 20'h2;
      #4;
      checks++;
      if (obs_byp_valid[1][1] !== 1'b1 || obs_byp_data[1][1] !== 64'd7) begin
         errors++;
         $display("FAIL resolve_slot1: got %b/%0d, expected 1/7", obs_byp_valid[1][1],
                  obs_byp_data[1][1]);
      end
      checks++;
      if (obs_resp_valid[0] !== 1'b1 || obs_resp_data[0] !== 64'd7) begin
         errors++;
         $display("FAIL resolve_resp_s1: got %b/%0d, expected 1/7", obs_resp_valid[0],
                  obs_resp_data[0]);
      end
      next_cycle();
      mispredict = '0;
      #4;
      checks++;
      if (obs_byp_valid[1][2] !== 1'b1) begin
         errors++;
         $display("FAIL resolve_slot2: got %b, expected 1", obs_byp_valid[1][2]);
      end
      next_cycle();
      #4;
      checks++;
      if (obs_resp_valid[1] !== 1'b1 || obs_resp_data[1] !== 64'd7) begin
         errors++;
         $display("FAIL resolve_resp_s3: got %b/%0d, expected 1/7", obs_resp_valid[1],
                  obs_resp_data[1]);
      end
      next_cycle();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) begin
         issue(4'd0, 1'b1, 64'(i * 10 + 1), 64'd0, '0, 7'(20 + i), 7'(30 + i));
         flush = (i == 2);
         if (i == 2) begin
            #4;
            checks++;
            if (obs_byp_valid[2][0] !== 1'b0) begin
               errors++;
               $display("FAIL flush_slot0: got %b, expected 0", obs_byp_valid[2][0]);
            end
         end
         next_cycle();
      end
      clear_inputs();
      #4;
      checks++;
      if (obs_busy[2] !== 1'b1 || obs_byp_valid[2][1] !== 1'b1 || obs_byp_valid[2][2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_c4: got busy=%b s1=%b s2=%b, expected 1/1/0", obs_busy[2],
                  obs_byp_valid[2][1], obs_byp_valid[2][2]);
      end
      for (int c = 4; c <= 7; c++) begin
         if (c > 4) #4;
         checks++;
         if (obs_resp_valid[2] !== (c == 7)) begin
            errors++;
            $display("FAIL flush_resp c%0d: got %b, expected %b", c, obs_resp_valid[2], c == 7);
         end
         if (c == 7) begin
            checks++;
            if (obs_resp_data[2] !== 64'd31 || obs_resp_rob[2] !== 7'd23) begin
               errors++;
               $display("FAIL flush_resp_data: got %0d rob=%0d, expected 31 rob=23",
                        obs_resp_data[2], obs_resp_rob[2]);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      issue(4'd4, 1'b1, 64'hF0, 64'h0F, '0, 7'd5, 7'd6);
      next_cycle();
      issue(4'd6, 1'b1, 64'h100, 64'h1, '0, 7'd6, 7'd7);
      next_cycle();
      clear_inputs();
      #1 reset = 1'b0;
      #3;
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (obs_busy[g] !== 1'b0 || obs_resp_valid[g] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cfg%0d: got busy=%b resp=%b, expected 0/0", g,
                     obs_busy[g], obs_resp_valid[g]);
         end
         for (int k = 1; k < stg(g); k++) begin
            checks++;
            if (obs_byp_valid[g][k] !== 1'b0) begin
               errors++;
               $display("FAIL reset_mid_byp cfg%0d slot%0d: got %b, expected 0", g, k,
                        obs_byp_valid[g][k]);
            end
         end
      end
      @(posedge clock);
      #1 reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #4;
         for (int g = 0; g < NCFG; g++) begin
            checks++;
            if (obs_resp_valid[g] !== 1'b0 || obs_busy[g] !== 1'b0) begin
               errors++;
               $display("FAIL reset_mid_after c%0d cfg%0d: got resp=%b busy=%b, expected 0/0",
                        c, g, obs_resp_valid[g], obs_busy[g]);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_random(input int n);
      uop_t        hist [4];
      uop_t        e;
      logic        vis, exp_busy, exp_s0;
      logic [63:0] exp_r;
      int          s, mode;
      for (int j = 0; j < 4; j++) hist[j] = '0;
      for (int c = 0; c < n; c++) begin
         req_valid     = ($urandom_range(0, 9) < 7);
         req_fn        = 4'($urandom_range(0, 15));
         req_dw        = 1'($urandom);
         mode          = $urandom_range(0, 3);
         req_in1       = {$urandom, $urandom};
         req_in2       = {$urandom, $urandom};
         if (mode == 1) begin
            req_in1 = 64'($urandom_range(0, 40));
            req_in2 = 64'($urandom_range(0, 40));
         end else if (mode == 2) begin
            req_in1 = ($urandom_range(0, 1) == 0) ? 64'h7FFF_FFFF : 64'h8000_0000_0000_0000;
            req_in2 = ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd63;
         end
         req_br_mask   = BMW'($urandom & 32'hF);
         req_rob_idx   = 7'($urandom);
         req_pdst      = 7'($urandom);
         req_dst_rtype = 2'($urandom);
         req_kill      = ($urandom_range(0, 9) == 0);
         resolve       = ($urandom_range(0, 2) == 0) ? (BMW'(1) << $urandom_range(0, 3)) : '0;
         mispredict    = ($urandom_range(0, 7) == 0) ? (BMW'(1) << $urandom_range(0, 3)) : '0;
         flush         = ($urandom_range(0, 29) == 0);
         exp_r         = alu_ref(req_fn, req_dw, req_in1, req_in2);
         exp_s0        = req_valid && !req_kill && !flush;
         #4;
         for (int g = 0; g < NCFG; g++) begin
            s   = stg(g);
            e   = hist[s-1];
            vis = e.alive && !flush && ((mispredict & e.mask) == '0);
            checks++;
            if (obs_resp_valid[g] !== vis) begin
               errors++;
               $display("FAIL rand c%0d cfg%0d resp_valid: got %b expected %b", c, g,
                        obs_resp_valid[g], vis);
            end
            if (vis) begin
               checks++;
               if ({obs_resp_data[g], obs_resp_rob[g], obs_resp_pdst[g], obs_resp_rtype[g]} !==
                   {e.data, e.rob, e.pdst, e.rtype}) begin
                  errors++;
                  $display("FAIL rand c%0d cfg%0d resp: got %h/%0d/%0d/%0d expected %h/%0d/%0d/%0d",
                           c, g, obs_resp_data[g], obs_resp_rob[g], obs_resp_pdst[g],
                           obs_resp_rtype[g], e.data, e.rob, e.pdst, e.rtype);
               end
            end
            checks++;
            if (obs_byp_valid[g][0] !== exp_s0) begin
               errors++;
               $display("FAIL rand c%0d cfg%0d slot0_valid: got %b expected %b", c, g,
                        obs_byp_valid[g][0], exp_s0);
            end
            if (exp_s0) begin
               checks++;
               if ({obs_byp_data[g][0], obs_byp_pdst[g][0], obs_byp_rtype[g][0]} !==
                   {exp_r, req_pdst, req_dst_rtype}) begin
                  errors++;
                  $display("FAIL rand c%0d cfg%0d slot0 fn=%0d dw=%b: got %h expected %h",
                           c, g, req_fn, req_dw, obs_byp_data[g][0], exp_r);
               end
            end
            for (int k = 1; k < s; k++) begin
               e   = hist[k-1];
               vis = e.alive && !flush && ((mispredict & e.mask) == '0);
               checks++;
               if (obs_byp_valid[g][k] !== vis) begin
                  errors++;
                  $display("FAIL rand c%0d cfg%0d slot%0d_valid: got %b expected %b", c, g, k,
                           obs_byp_valid[g][k], vis);
               end
               if (vis) begin
                  checks++;
                  if ({obs_byp_data[g][k], obs_byp_pdst[g][k], obs_byp_rtype[g][k]} !==
                      {e.data, e.pdst, e.rtype}) begin
                     errors++;
                     $display("FAIL rand c%0d cfg%0d slot%0d: got %h/%0d expected %h/%0d", c, g,
                              k, obs_byp_data[g][k], obs_byp_pdst[g][k], e.data, e.pdst);
                  end
               end
            end
            exp_busy = 1'b0;
            for (int j = 0; j < s; j++) exp_busy |= hist[j].alive;
            checks++;
            if (obs_busy[g] !== exp_busy) begin
               errors++;
               $display("FAIL rand c%0d cfg%0d busy: got %b expected %b", c, g, obs_busy[g],
                        exp_busy);
            end
         end
         @(posedge clock);
         // Age every in-flight uop by one cycle under this cycle's kills and resolves.
         for (int j = 3; j >= 1; j--) begin
            hist[j]       = hist[j-1];
            hist[j].alive = hist[j-1].alive && !flush && ((mispredict & hist[j-1].mask) == '0);
            hist[j].mask  = hist[j-1].mask & ~resolve;
         end
         hist[0].alive = exp_s0 && ((mispredict & req_br_mask) == '0);
         hist[0].mask  = req_br_mask & ~resolve;
         hist[0].data  = exp_r;
         hist[0].rob   = req_rob_idx;
         hist[0].pdst  = req_pdst;
         hist[0].rtype = req_dst_rtype;
         #1;
      end
      clear_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_alu();
      idle(6);
      test_mispredict();
      idle(6);
      test_resolve();
      idle(6);
      test_flush();
      idle(6);
      test_reset_mid();
      idle(6);
      test_random(600);
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
